// File: rtl/lut_neuron_bank.sv
// Reloadable bank of LUT neurons behind a two-stage elastic valid/ready pipeline.
// Tables live in flops and are rewritten at run time through the cfg_* port.
module lut_neuron_bank #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int NEURONS  = 4,
    localparam int CW      = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NEURONS*IN_BITS-1:0]   in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NEURONS*OUT_BITS-1:0]  out_data,
    input  logic                         cfg_we,
    input  logic [CW-1:0]                cfg_neuron,
    input  logic [IN_BITS-1:0]           cfg_addr,
    input  logic [OUT_BITS-1:0]          cfg_data,
    output logic                         cfg_err
);

    localparam int DEPTH = 1 << IN_BITS;
    localparam logic [CW:0] NEURONS_W = (CW + 1)'(NEURONS);

    logic [OUT_BITS-1:0]         table_q [NEURONS][DEPTH];
    logic [OUT_BITS-1:0]         table_d [NEURONS][DEPTH];
    logic                        cfg_err_q, cfg_err_d;

    logic [NEURONS*IN_BITS-1:0]  s1_data_q, s1_data_d;
    logic                        s1_valid_q, s1_valid_d;
    logic [NEURONS*OUT_BITS-1:0] out_data_q, out_data_d;
    logic                        s2_valid_q, s2_valid_d;

    logic                        s1_adv, s2_adv;
    logic [NEURONS*OUT_BITS-1:0] lookup;

    // Writes go straight into table_d, so a lookup on the same edge still sees table_q.
    always_comb begin
        table_d   = table_q;
        cfg_err_d = cfg_err_q;
        if (cfg_we) begin
            if ({1'b0, cfg_neuron} < NEURONS_W) begin
                table_d[cfg_neuron][cfg_addr] = cfg_data;
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        lookup = '0;
        for (int n = 0; n < NEURONS; n++) begin
            lookup[n*OUT_BITS +: OUT_BITS] = table_q[n][s1_data_q[n*IN_BITS +: IN_BITS]];
        end
    end

    always_comb begin
        s2_adv     = !s2_valid_q || out_ready;
        s1_adv     = !s1_valid_q || s2_adv;
        s1_data_d  = s1_data_q;
        s1_valid_d = s1_valid_q;
        out_data_d = out_data_q;
        s2_valid_d = s2_valid_q;

        if (in_valid && s1_adv) begin
            s1_data_d  = in_data;
            s1_valid_d = 1'b1;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_valid_q && s2_adv) begin
            out_data_d = lookup;
            s2_valid_d = 1'b1;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int n = 0; n < NEURONS; n++) begin
                for (int a = 0; a < DEPTH; a++) begin
                    table_q[n][a] <= '0;
                end
            end
            cfg_err_q  <= 1'b0;
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
            out_data_q <= '0;
            s2_valid_q <= 1'b0;
        end else begin
            table_q    <= table_d;
            cfg_err_q  <= cfg_err_d;
            s1_data_q  <= s1_data_d;
            s1_valid_q <= s1_valid_d;
            out_data_q <= out_data_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign out_data  = out_data_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_lut_neuron_bank.sv
// Self-checking bench: default-parameter bank for directed tables, and a
// 5-neuron/6-bit/2-bit bank for config errors and a randomized soak.
module tb_lut_neuron_bank;

    logic clk;
    logic rst;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data;
    logic [3:0]  a_out_data;
    logic        a_cfg_we, a_cfg_err;
    logic [1:0]  a_cfg_neuron;
    logic [7:0]  a_cfg_addr;
    logic [0:0]  a_cfg_data;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [29:0] b_in_data;
    logic [9:0]  b_out_data;
    logic        b_cfg_we, b_cfg_err;
    logic [2:0]  b_cfg_neuron;
    logic [5:0]  b_cfg_addr;
    logic [1:0]  b_cfg_data;

    int checks   = 0;
    int failures = 0;

    lut_neuron_bank dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .cfg_we(a_cfg_we), .cfg_neuron(a_cfg_neuron), .cfg_addr(a_cfg_addr),
        .cfg_data(a_cfg_data), .cfg_err(a_cfg_err)
    );

    lut_neuron_bank #(.IN_BITS(6), .OUT_BITS(2), .NEURONS(5)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .cfg_we(b_cfg_we), .cfg_neuron(b_cfg_neuron), .cfg_addr(b_cfg_addr),
        .cfg_data(b_cfg_data), .cfg_err(b_cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic [3:0]  exp;
    } vec_t;

    typedef struct {
        logic [29:0] addr;
        logic        done;
        logic [9:0]  res;
    } ent_t;

    logic [31:0] stim_q[$];
    logic [3:0]  exp_q[$];
    logic [1:0]  ref_b [5][64];
    ent_t        mq[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] word);
        a_in_valid = valid;
        a_in_data  = word;
    endtask

    task automatic cfgWriteA(input logic [1:0] n, input logic [7:0] addr, input logic d);
        @(negedge clk);
        a_cfg_we = 1'b1; a_cfg_neuron = n; a_cfg_addr = addr; a_cfg_data = d;
        @(negedge clk);
        a_cfg_we = 1'b0;
    endtask

    task automatic cfgWriteB(input logic [2:0] n, input logic [5:0] addr, input logic [1:0] d);
        @(negedge clk);
        b_cfg_we = 1'b1; b_cfg_neuron = n; b_cfg_addr = addr; b_cfg_data = d;
        @(negedge clk);
        b_cfg_we = 1'b0;
    endtask

    // Back-to-back stream through dut_a; result of word j is due before edge j+2.
    task automatic streamA();
        int n;
        n = stim_q.size();
        a_out_ready = 1'b1;
        for (int j = 0; j < n + 2; j++) begin
            @(negedge clk);
            if (j >= 2) begin
                checkOutput("stream_valid", 32'(a_out_valid), 32'd1);
                checkOutput("stream_data", 32'(a_out_data), 32'(exp_q[j-2]));
            end
            if (j < n) begin
                applyStimulus(1'b1, stim_q[j]);
                #1 checkOutput("stream_ready", 32'(a_in_ready), 32'd1);
            end else begin
                applyStimulus(1'b0, 32'd0);
            end
        end
        @(negedge clk);
        checkOutput("stream_drain", 32'(a_out_valid), 32'd0);
        stim_q.delete();
        exp_q.delete();
    endtask

    function automatic logic [9:0] refLookup(input logic [29:0] addr);
        logic [9:0] r;
        for (int n = 0; n < 5; n++) begin
            r[n*2 +: 2] = ref_b[n][addr[n*6 +: 6]];
        end
        return r;
    endfunction

    vec_t vecs[6];

    initial begin
        logic       exp_valid, has_pending, s2adv, exp_ready, err_model;
        logic [9:0] exp_res;
        ent_t       e;

        vecs[0] = '{word: {8'h00, 8'hA5, 8'h00, 8'h00}, exp: 4'b0100};
        vecs[1] = '{word: {8'h00, 8'hA4, 8'h00, 8'h00}, exp: 4'b0000};
        vecs[2] = '{word: {8'h7F, 8'hA5, 8'hFF, 8'h33}, exp: 4'b1111};
        vecs[3] = '{word: {8'h7F, 8'hA4, 8'hFE, 8'h33}, exp: 4'b1001};
        vecs[4] = '{word: {8'h00, 8'hA5, 8'hFF, 8'h00}, exp: 4'b0110};
        vecs[5] = '{word: {8'h7E, 8'h00, 8'h00, 8'h33}, exp: 4'b0001};

        rst = 1'b1;
        a_in_valid = 0; a_in_data = '0; a_out_ready = 1; a_cfg_we = 0;
        a_cfg_neuron = '0; a_cfg_addr = '0; a_cfg_data = '0;
        b_in_valid = 0; b_in_data = '0; b_out_ready = 1; b_cfg_we = 0;
        b_cfg_neuron = '0; b_cfg_addr = '0; b_cfg_data = '0;

        // Reset while input and config strobes are active
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 32'hFFFF_FFFF);
        a_cfg_we = 1; a_cfg_neuron = 2'd1; a_cfg_addr = 8'h03; a_cfg_data = 1'b1;
        b_in_valid = 1; b_cfg_we = 1; b_cfg_neuron = 3'd7;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 32'd0);
        a_cfg_we = 0; b_cfg_we = 0; b_in_valid = 0;
        #1;
        checkOutput("rst_out_valid", 32'(a_out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(a_out_data), 32'd0);
        checkOutput("rst_cfg_err", 32'(a_cfg_err), 32'd0);
        checkOutput("rst_in_ready", 32'(a_in_ready), 32'd1);
        checkOutput("rst_b_cfg_err", 32'(b_cfg_err), 32'd0);
        checkOutput("rst_b_out_valid", 32'(b_out_valid), 32'd0);

        for (int i = 0; i < 256; i++) begin
            stim_q.push_back({4{8'(i)}});
            exp_q.push_back(4'b0000);
        end
        streamA();

        // Program a few entries and stream the vector table
        cfgWriteA(2'd2, 8'hA5, 1'b1);
        cfgWriteA(2'd0, 8'h33, 1'b1);
        cfgWriteA(2'd1, 8'hFF, 1'b1);
        cfgWriteA(2'd3, 8'h7F, 1'b1);
        for (int i = 0; i < 6; i++) begin
            stim_q.push_back(vecs[i].word);
            exp_q.push_back(vecs[i].exp);
        end
        streamA();

        // Backpressure: two words absorbed, third refused until out_ready rises
        a_out_ready = 1'b0;
        @(negedge clk); applyStimulus(1'b1, {8'h7F, 8'hA5, 8'hFF, 8'h33});
        #1 checkOutput("bp_ready_w0", 32'(a_in_ready), 32'd1);
        @(negedge clk); applyStimulus(1'b1, {8'h00, 8'hA4, 8'h00, 8'h00});
        #1 checkOutput("bp_ready_w1", 32'(a_in_ready), 32'd1);
        @(negedge clk); applyStimulus(1'b1, {8'h00, 8'hA5, 8'h00, 8'h33});
        #1 checkOutput("bp_full_ready", 32'(a_in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp_stall_ready", 32'(a_in_ready), 32'd0);
            checkOutput("bp_stall_valid", 32'(a_out_valid), 32'd1);
            checkOutput("bp_stall_data", 32'(a_out_data), 32'hF);
        end
        a_out_ready = 1'b1;
        #1 checkOutput("bp_release_ready", 32'(a_in_ready), 32'd1);
        @(negedge clk); applyStimulus(1'b0, 32'd0);
        checkOutput("bp_out1_valid", 32'(a_out_valid), 32'd1);
        checkOutput("bp_out1_data", 32'(a_out_data), 32'h0);
        @(negedge clk);
        checkOutput("bp_out2_valid", 32'(a_out_valid), 32'd1);
        checkOutput("bp_out2_data", 32'(a_out_data), 32'h5);
        @(negedge clk);
        checkOutput("bp_empty", 32'(a_out_valid), 32'd0);

        // Collision: write lands on the same edge S1 looks up entry 0x10
        @(negedge clk); applyStimulus(1'b1, 32'h0000_0010);
        @(negedge clk); applyStimulus(1'b0, 32'd0);
        a_cfg_we = 1; a_cfg_neuron = 2'd0; a_cfg_addr = 8'h10; a_cfg_data = 1'b1;
        @(negedge clk); a_cfg_we = 0;
        checkOutput("coll_valid", 32'(a_out_valid), 32'd1);
        checkOutput("coll_old_value", 32'(a_out_data), 32'h0);
        stim_q.push_back(32'h0000_0010);
        exp_q.push_back(4'b0001);
        streamA();

        // Out-of-range neuron on the 5-neuron bank
        cfgWriteB(3'd6, 6'd0, 2'd3);
        checkOutput("cfgerr_set", 32'(b_cfg_err), 32'd1);
        repeat (2) @(negedge clk);
        checkOutput("cfgerr_held", 32'(b_cfg_err), 32'd1);
        cfgWriteB(3'd1, 6'd0, 2'd2);
        checkOutput("cfgerr_after_valid", 32'(b_cfg_err), 32'd1);
        b_out_ready = 1;
        @(negedge clk); b_in_valid = 1; b_in_data = '0;
        @(negedge clk); b_in_valid = 0;
        @(negedge clk);
        checkOutput("cfgerr_tbl_valid", 32'(b_out_valid), 32'd1);
        checkOutput("cfgerr_tbl_data", 32'(b_out_data), 32'h008);
        @(negedge clk); rst = 0;
        @(negedge clk); rst = 1;
        #1 checkOutput("cfgerr_reset", 32'(b_cfg_err), 32'd0);

        // Random soak against a transaction-level queue model
        for (int n = 0; n < 5; n++) for (int a = 0; a < 64; a++) ref_b[n][a] = 2'd0;
        mq.delete();
        err_model = 1'b0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            b_in_valid   = ($urandom_range(0, 2) != 0);
            b_in_data    = 30'($urandom);
            b_out_ready  = ($urandom_range(0, 3) != 0);
            b_cfg_we     = ($urandom_range(0, 3) == 0);
            b_cfg_neuron = 3'($urandom_range(0, 7));
            b_cfg_addr   = 6'($urandom);
            b_cfg_data   = 2'($urandom);
            #1;
            exp_valid   = (mq.size() > 0) && mq[0].done;
            has_pending = (mq.size() > 0) && !mq[mq.size()-1].done;
            s2adv       = !exp_valid || b_out_ready;
            exp_ready   = !has_pending || s2adv;
            checkOutput("soak_in_ready", 32'(b_in_ready), 32'(exp_ready));
            checkOutput("soak_out_valid", 32'(b_out_valid), 32'(exp_valid));
            if (exp_valid) checkOutput("soak_out_data", 32'(b_out_data), 32'(mq[0].res));
            checkOutput("soak_cfg_err", 32'(b_cfg_err), 32'(err_model));

            if (exp_valid && b_out_ready) void'(mq.pop_front());
            if (has_pending && s2adv) begin
                exp_res = refLookup(mq[mq.size()-1].addr);
                mq[mq.size()-1].done = 1'b1;
                mq[mq.size()-1].res  = exp_res;
            end
            if (b_in_valid && exp_ready) begin
                e.addr = b_in_data; e.done = 1'b0; e.res = '0;
                mq.push_back(e);
            end
            if (b_cfg_we) begin
                if (b_cfg_neuron < 3'd5) ref_b[b_cfg_neuron][b_cfg_addr] = b_cfg_data;
                else err_model = 1'b1;
            end
        end

        // Reset with words in flight: nothing may emerge afterwards
        @(negedge clk);
        b_cfg_we = 0; b_out_ready = 0; b_in_valid = 1; rst = 0;
        @(negedge clk);
        rst = 1; b_in_valid = 0; b_out_ready = 1;
        #1 checkOutput("midrst_valid0", 32'(b_out_valid), 32'd0);
        checkOutput("midrst_cfg_err", 32'(b_cfg_err), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("midrst_valid2", 32'(b_out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
